// File: rtl/ro_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ro_pkg
//  Description : Shared types and constants for the ring-oscillator entropy
//                sampler: FSM state encoding, output byte width and the
//                von Neumann pair codes that produce an output bit.
//  Revision    : 1.0 - initial release
// ============================================================================
package ro_pkg;

    // Sampler control states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WARMUP = 3'd1,
        SAMPLE = 3'd2,
        OUTPUT = 3'd3,
        FAULT  = 3'd4
    } ro_state_t;

    // Width of a delivered random byte
    localparam int BYTE_W = 8;

    // Von Neumann pair codes {first, second}: 01 -> bit 0, 10 -> bit 1.
    // 00 and 11 carry no information and are discarded.
    localparam logic [1:0] VN_PAIR_ZERO = 2'b01;
    localparam logic [1:0] VN_PAIR_ONE  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/ro_sync.sv
`default_nettype none
// ============================================================================
//  Module      : ro_sync
//  Description : Multi-flop synchronizer bringing the asynchronous ring
//                oscillator output into the clk domain. Resets to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module ro_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    // Shift the raw input through the flop chain; the last stage is safe to use
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/ro_entropy_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : ro_entropy_sampler
//  Description : Enables the ring oscillator, synchronizes its output,
//                samples it every SAMPLE_DIV clocks, debiases the stream with
//                von Neumann pairing and packs bits into bytes delivered on a
//                valid/ready handshake. Includes a stuck-oscillator detector
//                and a saturating rising-edge counter.
//                Build option RO_SAMPLER_RAW_EN: bypass the pairing so every
//                sample is shifted directly into the output byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module ro_entropy_sampler
    import ro_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int WARMUP_CYCLES = 16,
    parameter int SAMPLE_DIV    = 4,
    parameter int STUCK_LIMIT   = 64,
    parameter int EDGE_CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  ro_in,
    output logic                  ro_en,
    output logic [BYTE_W-1:0]     rnd_data,
    output logic                  rnd_valid,
    input  logic                  rnd_ready,
    output logic                  stuck_err,
    output logic [EDGE_CNT_W-1:0] edge_cnt
);

    localparam int WU_W      = $clog2(WARMUP_CYCLES + 1);
    localparam int DIV_W     = $clog2(SAMPLE_DIV);
    localparam int ST_W      = $clog2(STUCK_LIMIT + 1);
    localparam int BIT_CNT_W = $clog2(BYTE_W + 1);

    localparam logic [WU_W-1:0]      WU_LOAD  = WU_W'(WARMUP_CYCLES - 1);
    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [ST_W-1:0]      ST_LAST  = ST_W'(STUCK_LIMIT - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(BYTE_W - 1);

    logic                  w_s;
    logic                  r_s_d;
    ro_state_t             r_state;
    ro_state_t             w_state_nxt;
    logic [WU_W-1:0]       r_warm;
    logic [DIV_W-1:0]      r_div;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic [BYTE_W-1:0]     r_data;
    logic [ST_W-1:0]       r_stuck;
    logic [EDGE_CNT_W-1:0] r_edge;
    logic                  w_take_sample;
    logic                  w_emit;
    logic                  w_bit;
    logic                  w_byte_done;
    logic                  w_checking;
    logic                  w_stuck_hit;

    ro_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (ro_in),
        .o_q   (w_s)
    );

    assign w_take_sample = (r_state == SAMPLE) && (r_div == DIV_LAST);

`ifdef RO_SAMPLER_RAW_EN
    assign w_emit = w_take_sample;
    assign w_bit  = w_s;
`else
    logic       r_pair_flag;
    logic       r_first;
    logic [1:0] w_pair;

    assign w_pair = {r_first, w_s};
    assign w_emit = w_take_sample && r_pair_flag &&
                    ((w_pair == VN_PAIR_ZERO) || (w_pair == VN_PAIR_ONE));
    assign w_bit  = (w_pair == VN_PAIR_ONE);

    // Hold the first sample of each pair; any exit from SAMPLE drops a half pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pair_flag <= 1'b0;
            r_first     <= 1'b0;
        end else if (r_state != SAMPLE) begin
            r_pair_flag <= 1'b0;
            r_first     <= 1'b0;
        end else if (w_take_sample) begin
            r_pair_flag <= ~r_pair_flag;
            if (!r_pair_flag) begin
                r_first <= w_s;
            end
        end
    end
`endif

    assign w_byte_done = w_emit && (r_bit_cnt == BIT_LAST);
    assign w_checking  = (r_state == SAMPLE) || (r_state == OUTPUT);
    assign w_stuck_hit = w_checking && (w_s == r_s_d) && (r_stuck == ST_LAST);

    // Previous synced value, used for transition and rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_d <= 1'b0;
        end else begin
            r_s_d <= w_s;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and state-decoded outputs; a stuck fault beats byte/handshake
    always_comb begin
        w_state_nxt = r_state;
        ro_en       = 1'b0;
        rnd_valid   = 1'b0;
        stuck_err   = 1'b0;
        case (r_state)
            IDLE: begin
                if (en) begin
                    w_state_nxt = WARMUP;
                end
            end
            WARMUP: begin
                ro_en = 1'b1;
                if (!en) begin
                    w_state_nxt = IDLE;
                end else if (r_warm == '0) begin
                    w_state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                ro_en = 1'b1;
                if (!en) begin
                    w_state_nxt = IDLE;
                end else if (w_stuck_hit) begin
                    w_state_nxt = FAULT;
                end else if (w_byte_done) begin
                    w_state_nxt = OUTPUT;
                end
            end
            OUTPUT: begin
                ro_en     = 1'b1;
                rnd_valid = 1'b1;
                if (!en) begin
                    w_state_nxt = IDLE;
                end else if (w_stuck_hit) begin
                    w_state_nxt = FAULT;
                end else if (rnd_ready) begin
                    w_state_nxt = SAMPLE;
                end
            end
            FAULT: begin
                stuck_err = 1'b1;
                if (!en) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Warm-up countdown: loaded on enable, runs WARMUP_CYCLES cycles in WARMUP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_warm <= '0;
        end else if ((r_state == IDLE) && en) begin
            r_warm <= WU_LOAD;
        end else if ((r_state == WARMUP) && (r_warm != '0)) begin
            r_warm <= r_warm - 1'b1;
        end else if (r_state != WARMUP) begin
            r_warm <= '0;
        end
    end

    // Sample divider, bit count and output shift register; idle outside SAMPLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div     <= '0;
            r_bit_cnt <= '0;
            r_data    <= '0;
        end else if (r_state == SAMPLE) begin
            r_div <= w_take_sample ? '0 : r_div + 1'b1;
            if (w_emit) begin
                r_data    <= {r_data[BYTE_W-2:0], w_bit};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end else begin
            r_div     <= '0;
            r_bit_cnt <= '0;
        end
    end

    // Consecutive no-transition counter, live only while the oscillator is used
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stuck <= '0;
        end else if (!w_checking || (w_s != r_s_d)) begin
            r_stuck <= '0;
        end else if (r_stuck != ST_W'(STUCK_LIMIT)) begin
            r_stuck <= r_stuck + 1'b1;
        end
    end

    // Saturating synced rising-edge counter, restarted on each enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_edge <= '0;
        end else if ((r_state == IDLE) && en) begin
            r_edge <= '0;
        end else if ((r_state == SAMPLE) && w_s && !r_s_d &&
                     (r_edge != {EDGE_CNT_W{1'b1}})) begin
            r_edge <= r_edge + 1'b1;
        end
    end

    assign rnd_data = r_data;
    assign edge_cnt = r_edge;

endmodule
`default_nettype wire

// File: tb/tb_ro_entropy_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ro_entropy_sampler
//  Description : Self-checking bench for ro_entropy_sampler. A behavioural
//                model predicts mode, status outputs and every delivered byte;
//                a monitor compares the DUT against it each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ro_entropy_sampler;

    localparam int SYNC  = 2;
    localparam int WARM  = 16;
    localparam int DIV   = 4;
    localparam int LIMIT = 64;
    localparam int EW    = 10;
    localparam int EDGE_MAX = (1 << EW) - 1;

    localparam int M_IDLE   = 0;
    localparam int M_WARM   = 1;
    localparam int M_SAMPLE = 2;
    localparam int M_OUT    = 3;
    localparam int M_FAULT  = 4;

`ifdef RO_SAMPLER_RAW_EN
    localparam int         SAMPLES_PER_BYTE = 8;
    localparam logic [7:0] DIR_UNIT = 8'b1010_1100;
    localparam int         DIR_REPS = 1;
    localparam logic [7:0] DIR_BYTE = 8'hAC;
`else
    localparam int         SAMPLES_PER_BYTE = 16;
    localparam logic [7:0] DIR_UNIT = 8'b0110_0011;
    localparam int         DIR_REPS = 4;
    localparam logic [7:0] DIR_BYTE = 8'h55;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          ro_in = 1'b0;
    logic          rnd_ready = 1'b0;
    logic          ro_en;
    logic [7:0]    rnd_data;
    logic          rnd_valid;
    logic          stuck_err;
    logic [EW-1:0] edge_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    ro_entropy_sampler #(
        .SYNC_STAGES   (SYNC),
        .WARMUP_CYCLES (WARM),
        .SAMPLE_DIV    (DIV),
        .STUCK_LIMIT   (LIMIT),
        .EDGE_CNT_W    (EW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .ro_in     (ro_in),
        .ro_en     (ro_en),
        .rnd_data  (rnd_data),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready),
        .stuck_err (stuck_err),
        .edge_cnt  (edge_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input string why);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s (t=%0t)", name, why, $time);
    endtask

    // ---------------- behavioural model ----------------
    int         m_mode;
    int         m_warm_left;
    int         m_phase;
    int         m_quiet;
    int         m_edges;
    bit         m_syn[SYNC];
    bit         m_sd;
    bit         m_pend_q[$];
    bit         m_bits[$];
    logic [7:0] exp_q[$];

    task automatic model_reset();
        m_mode = M_IDLE; m_warm_left = 0; m_phase = 0; m_quiet = 0; m_edges = 0;
        for (int i = 0; i < SYNC; i++) m_syn[i] = 1'b0;
        m_sd = 1'b0;
        m_pend_q.delete(); m_bits.delete(); exp_q.delete();
    endtask

    task automatic clear_bytes();
        m_phase = 0;
        m_pend_q.delete();
        m_bits.delete();
    endtask

    task automatic take_sample(input bit s, output bit done, output logic [7:0] b);
        bit have_bit;
        bit v;
        done = 1'b0;
        b = 8'h00;
        have_bit = 1'b0;
        v = 1'b0;
`ifdef RO_SAMPLER_RAW_EN
        have_bit = 1'b1;
        v = s;
`else
        if (m_pend_q.size() == 0) begin
            m_pend_q.push_back(s);
        end else begin
            v = m_pend_q.pop_front();
            have_bit = (v != s);
        end
`endif
        if (have_bit) begin
            m_bits.push_back(v);
            if (m_bits.size() == 8) begin
                for (int i = 0; i < 8; i++) b = {b[6:0], m_bits[i]};
                m_bits.delete();
                done = 1'b1;
            end
        end
    endtask

    task automatic model_step();
        bit s;
        bit done;
        logic [7:0] b;
        s = m_syn[SYNC-1];
        done = 1'b0;
        b = 8'h00;
        if (m_mode == M_SAMPLE || m_mode == M_OUT) m_quiet = (s != m_sd) ? 0 : m_quiet + 1;
        else m_quiet = 0;
        case (m_mode)
            M_IDLE: if (en) begin
                m_mode = M_WARM; m_warm_left = WARM; m_edges = 0;
            end
            M_WARM: begin
                if (!en) begin
                    m_mode = M_IDLE;
                end else begin
                    m_warm_left--;
                    if (m_warm_left == 0) begin m_mode = M_SAMPLE; clear_bytes(); end
                end
            end
            M_SAMPLE: begin
                if (s && !m_sd && m_edges < EDGE_MAX) m_edges++;
                m_phase++;
                if (m_phase == DIV) begin m_phase = 0; take_sample(s, done, b); end
                if (!en) begin m_mode = M_IDLE; clear_bytes(); end
                else if (m_quiet >= LIMIT) m_mode = M_FAULT;
                else if (done) begin m_mode = M_OUT; exp_q.push_back(b); end
            end
            M_OUT: begin
                if (!en || m_quiet >= LIMIT) begin
                    if (!rnd_ready && exp_q.size() > 0) void'(exp_q.pop_back());
                    m_mode = en ? M_FAULT : M_IDLE;
                    clear_bytes();
                end else if (rnd_ready) begin
                    m_mode = M_SAMPLE; clear_bytes();
                end
            end
            default: if (!en) m_mode = M_IDLE;
        endcase
        m_sd = s;
        for (int i = SYNC - 1; i > 0; i--) m_syn[i] = m_syn[i-1];
        m_syn[0] = ro_in;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        check("ro_en", ro_en, (m_mode == M_WARM || m_mode == M_SAMPLE || m_mode == M_OUT));
        check("rnd_valid", rnd_valid, (m_mode == M_OUT));
        check("stuck_err", stuck_err, (m_mode == M_FAULT));
        check("edge_cnt", edge_cnt, m_edges);
        if (rnd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                fail_now("rnd_data", "byte presented with none predicted");
            end else begin
                check("rnd_data", rnd_data, exp_q[0]);
                if (rnd_ready) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    int tog_cnt = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_ro(input int lo, input int hi);
        if (tog_cnt <= 0) begin
            ro_in = ~ro_in;
            tog_cnt = $urandom_range(hi, lo);
        end else begin
            tog_cnt--;
        end
    endtask

    task automatic restart();
        en = 1'b0;
        rnd_ready = 1'b0;
        repeat (2) tick();
        en = 1'b1;
    endtask

    initial begin
        int n;
        bit pat[$];
        model_reset();

        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        check("reset_rnd_data", rnd_data, 8'h00);
        check("reset_edge_cnt", edge_cnt, 0);
        check("reset_ro_en", ro_en, 1'b0);
        check("reset_rnd_valid", rnd_valid, 1'b0);
        check("reset_stuck_err", stuck_err, 1'b0);
        rst_n = 1'b1;
        tick();

        // Enable with ro_in toggling every 3 clocks
        en = 1'b1;
        check("ro_en_before_en_seen", ro_en, 1'b0);
        tick();
        check("ro_en_after_en", ro_en, 1'b1);
        n = 1;
        while (!rnd_valid && n < 400) begin
            if (n % 3 == 0) ro_in = ~ro_in;
            tick();
            n++;
        end
        if (!rnd_valid) fail_now("first_byte", "timed out waiting for rnd_valid");
        else check("first_byte_latency_ok", (n >= WARM + SAMPLES_PER_BYTE * DIV), 1'b1);

        // Randomized run with random ready, rare enable drops and one mid reset
        for (int i = 0; i < 3000; i++) begin
            step_ro(1, 5);
            rnd_ready = ($urandom_range(0, 2) == 0);
            en = ($urandom_range(0, 299) != 0);
            if (i == 1500) begin
                rst_n = 1'b0;
                tick();
                check("midreset_rnd_data", rnd_data, 8'h00);
                check("midreset_rnd_valid", rnd_valid, 1'b0);
                check("midreset_edge_cnt", edge_cnt, 0);
                rst_n = 1'b1;
            end
            tick();
        end

        // Directed sample pattern -> known byte, held while not ready
        restart();
        n = 0;
        while (m_mode != M_SAMPLE && n < 60) begin tick(); n++; end
        if (m_mode != M_SAMPLE) fail_now("dir_enter_sample", "timed out waiting for SAMPLE");
        for (int r = 0; r < DIR_REPS; r++)
            for (int k = 7; k >= 0; k--) pat.push_back(DIR_UNIT[k]);
        tick();
        foreach (pat[i]) begin
            ro_in = pat[i];
            repeat (DIV) tick();
        end
        n = 0;
        while (!rnd_valid && n < 10) begin tick(); n++; end
        check("dir_valid", rnd_valid, 1'b1);
        check("dir_byte", rnd_data, DIR_BYTE);
        repeat (10) tick();
        check("dir_hold_valid", rnd_valid, 1'b1);
        check("dir_hold_byte", rnd_data, DIR_BYTE);
        rnd_ready = 1'b1;
        tick();
        rnd_ready = 1'b0;
        check("dir_valid_after_handshake", rnd_valid, 1'b0);

        // Stuck oscillator fault
        restart();
        rnd_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (i % 3 == 0) ro_in = ~ro_in;
            tick();
        end
        ro_in = 1'b0;
        repeat (3) tick();
        ro_in = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!stuck_err && n < 200);
        check("stuck_latency", n, LIMIT + SYNC + 1);
        check("stuck_ro_en", ro_en, 1'b0);
        check("stuck_rnd_valid", rnd_valid, 1'b0);
        en = 1'b0;
        tick();
        check("stuck_cleared", stuck_err, 1'b0);

        // Drop enable while a byte is waiting
        restart();
        n = 0;
        while (!rnd_valid && n < 3000) begin step_ro(1, 4); tick(); n++; end
        if (!rnd_valid) fail_now("drop_wait_valid", "timed out waiting for rnd_valid");
        en = 1'b0;
        tick();
        check("drop_rnd_valid", rnd_valid, 1'b0);
        check("drop_ro_en", ro_en, 1'b0);
        en = 1'b1;
        tick();
        check("reenable_edge_cnt", edge_cnt, 0);
        check("reenable_ro_en", ro_en, 1'b1);

        // Fastest toggling: edge counter must saturate
        rnd_ready = 1'b1;
        for (int i = 0; i < 2 * ((1 << EW) + 10) + 2 * WARM + 20; i++) begin
            ro_in = ~ro_in;
            tick();
        end
        check("edge_cnt_saturated", edge_cnt, EDGE_MAX);
        repeat (6) begin ro_in = ~ro_in; tick(); end
        check("edge_cnt_held_at_max", edge_cnt, EDGE_MAX);

        en = 1'b0;
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
